// File: rtl/rst_req_rsp.sv
// rst_req_rsp: power-on hold and masked per-channel reset request/ack sequencer
module rst_req_rsp #(
   parameter int HOLD_CNT = 10,
   parameter int WAIT_MAX = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [3:0] req_mask,
   input  logic [3:0] ch_ready,
   output logic [3:0] resetB,
   output logic       busy,
   output logic       ack,
   output logic       timeout,
   output logic       req_drop,
   output logic       por_done
);
   typedef enum logic [2:0] {POR_HOLD, IDLE, ASSERT, WAIT_RDY, DONE} state_t;
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CNT - 1);
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
   state_t     state;
   logic [7:0] cnt;
   logic [3:0] msk;
   logic       rdy;
   assign rdy = (ch_ready & msk) == msk;
   // Sequencer: state, hold/wait counter, latched mask and all registered outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= POR_HOLD;
         cnt      <= 8'd0;
         msk      <= 4'b1111;
         resetB   <= 4'b0000;
         busy     <= 1'b1;
         ack      <= 1'b0;
         timeout  <= 1'b0;
         req_drop <= 1'b0;
         por_done <= 1'b0;
      end else begin
         ack      <= 1'b0;
         timeout  <= 1'b0;
         req_drop <= req && state != IDLE;
         cnt      <= cnt + 8'd1;
         case (state)
            POR_HOLD:
               if (cnt == HOLD_LAST) begin
                  state    <= IDLE;
                  cnt      <= 8'd0;
                  resetB   <= 4'b1111;
                  por_done <= 1'b1;
                  busy     <= 1'b0;
               end
            IDLE: begin
               cnt <= 8'd0;
               if (req && req_mask != 4'b0000) begin
                  state  <= ASSERT;
                  msk    <= req_mask;
                  resetB <= resetB & ~req_mask;
                  busy   <= 1'b1;
               end else if (req) begin
                  ack <= 1'b1;
               end
            end
            ASSERT:
               if (cnt == HOLD_LAST) begin
                  state  <= WAIT_RDY;
                  cnt    <= 8'd0;
                  resetB <= 4'b1111;
               end
            WAIT_RDY:
               if (rdy || cnt == WAIT_LAST) begin
                  state   <= DONE;
                  cnt     <= 8'd0;
                  ack     <= 1'b1;
                  timeout <= !rdy;
               end
            DONE: begin
               state <= IDLE;
               cnt   <= 8'd0;
               busy  <= 1'b0;
            end
            default: state <= POR_HOLD;
         endcase
      end
endmodule

// File: tb/tb_rst_req_rsp.sv
// tb_rst_req_rsp: scoreboard bench for the reset-request responder
module tb_rst_req_rsp;
   typedef struct {int cyc; logic to;} exp_t;
   logic       clk = 0, rst = 1, req = 0;
   logic [3:0] req_mask = 0, ch_ready = 0;
   logic [3:0] resetB;
   logic       busy, ack, timeout, req_drop, por_done;
   exp_t       sb[$];
   exp_t       e;
   int         passed = 0, total = 0, cyc = 0, acks = 0, a0;
   bit         ok;

   rst_req_rsp #(.HOLD_CNT(10), .WAIT_MAX(200)) dut (
      .clk(clk), .rst(rst), .req(req), .req_mask(req_mask), .ch_ready(ch_ready),
      .resetB(resetB), .busy(busy), .ack(ack), .timeout(timeout),
      .req_drop(req_drop), .por_done(por_done));

   always #5 clk = ~clk;
   // Edge counter used to timestamp expected acks
   always @(posedge clk) cyc++;
   // Counts ack pulses to catch spurious or lost acknowledges
   always @(negedge clk) if (ack) acks++;

   task tick;
      @(posedge clk);
      #1;
   endtask

   task wait_ack(input int lim, output bit got);
      got = 0;
      for (int i = 0; i < lim; i++) begin
         if (ack) begin
            got = 1;
            return;
         end
         tick;
      end
      got = ack;
   endtask

   task test_reset;
      rst = 1;
      tick;
      tick;
      total++;
      if ({resetB, busy, ack, timeout, req_drop, por_done} !== 9'b0000_1_0000)
         $display("FAIL reset_vals got %b want 000010000", {resetB, busy, ack, timeout, req_drop, por_done});
      else passed++;
      rst = 0;
      for (int i = 0; i < 9; i++) begin
         req = (i == 3);
         req_mask = 4'b0001;
         tick;
         total++;
         if (resetB !== 4'b0000 || por_done !== 1'b0)
            $display("FAIL por_hold[%0d] resetB=%b por_done=%b want 0000/0", i, resetB, por_done);
         else passed++;
         if (i == 3) begin
            total++;
            if (req_drop !== 1'b1) $display("FAIL por_req_drop got %b want 1", req_drop);
            else passed++;
         end
      end
      req = 0;
      tick;
      total++;
      if (resetB !== 4'b1111 || por_done !== 1'b1)
         $display("FAIL por_release resetB=%b por_done=%b want 1111/1", resetB, por_done);
      else passed++;
      tick;
      total++;
      if (busy !== 1'b0 || por_done !== 1'b1 || req_drop !== 1'b0)
         $display("FAIL por_idle busy=%b por_done=%b req_drop=%b want 0/1/0", busy, por_done, req_drop);
      else passed++;
   endtask

   task test_mask_0101;
      ch_ready = 4'b1111;
      req = 1;
      req_mask = 4'b0101;
      tick;
      req = 0;
      sb.push_back('{cyc + 11, 1'b0});
      for (int i = 0; i < 10; i++) begin
         total++;
         if (resetB !== 4'b1010 || busy !== 1'b1)
            $display("FAIL m0101_hold[%0d] resetB=%b busy=%b want 1010/1", i, resetB, busy);
         else passed++;
         tick;
      end
      total++;
      if (resetB !== 4'b1111 || ack !== 1'b0)
         $display("FAIL m0101_release resetB=%b ack=%b want 1111/0", resetB, ack);
      else passed++;
      wait_ack(20, ok);
      e = sb.pop_front();
      total++;
      if (!ok) $display("FAIL m0101_ack missing, want at cycle %0d", e.cyc);
      else if (cyc !== e.cyc || timeout !== e.to)
         $display("FAIL m0101_ack cycle=%0d timeout=%b want %0d/%b", cyc, timeout, e.cyc, e.to);
      else passed++;
      tick;
      total++;
      if (ack !== 1'b0 || busy !== 1'b0)
         $display("FAIL m0101_idle ack=%b busy=%b want 0/0", ack, busy);
      else passed++;
   endtask

   task test_timeout;
      ch_ready = 4'b1101;
      req = 1;
      req_mask = 4'b0010;
      tick;
      req = 0;
      sb.push_back('{cyc + 210, 1'b1});
      total++;
      if (resetB !== 4'b1101) $display("FAIL to_assert resetB=%b want 1101", resetB);
      else passed++;
      wait_ack(300, ok);
      e = sb.pop_front();
      total++;
      if (!ok) $display("FAIL to_ack missing, want at cycle %0d", e.cyc);
      else if (cyc !== e.cyc || timeout !== e.to)
         $display("FAIL to_ack cycle=%0d timeout=%b want %0d/%b", cyc, timeout, e.cyc, e.to);
      else passed++;
      tick;
      total++;
      if (ack !== 1'b0 || timeout !== 1'b0)
         $display("FAIL to_pulse ack=%b timeout=%b want 0/0", ack, timeout);
      else passed++;
   endtask

   task test_ready_late;
      ch_ready = 4'b0111;
      req = 1;
      req_mask = 4'b1111;
      tick;
      req = 0;
      a0 = acks;
      repeat (50) tick;
      total++;
      if (acks !== a0 || ack !== 1'b0 || busy !== 1'b1)
         $display("FAIL late_wait acks=%0d ack=%b busy=%b want %0d/0/1", acks, ack, busy, a0);
      else passed++;
      ch_ready = 4'b1111;
      sb.push_back('{cyc + 1, 1'b0});
      wait_ack(5, ok);
      e = sb.pop_front();
      total++;
      if (!ok) $display("FAIL late_ack missing, want at cycle %0d", e.cyc);
      else if (cyc !== e.cyc || timeout !== e.to)
         $display("FAIL late_ack cycle=%0d timeout=%b want %0d/%b", cyc, timeout, e.cyc, e.to);
      else passed++;
   endtask

   task test_back_to_back;
      ch_ready = 4'b1111;
      tick;
      req = 1;
      req_mask = 4'b0001;
      tick;
      req = 0;
      sb.push_back('{cyc + 11, 1'b0});
      a0 = acks;
      repeat (3) tick;
      req = 1;
      req_mask = 4'b1110;
      tick;
      req = 0;
      total++;
      if (req_drop !== 1'b1 || resetB !== 4'b1110)
         $display("FAIL drop_assert req_drop=%b resetB=%b want 1/1110", req_drop, resetB);
      else passed++;
      tick;
      total++;
      if (req_drop !== 1'b0 || resetB !== 4'b1110)
         $display("FAIL drop_clear req_drop=%b resetB=%b want 0/1110", req_drop, resetB);
      else passed++;
      wait_ack(20, ok);
      e = sb.pop_front();
      total++;
      if (!ok) $display("FAIL drop_ack missing, want at cycle %0d", e.cyc);
      else if (cyc !== e.cyc || timeout !== e.to)
         $display("FAIL drop_ack cycle=%0d timeout=%b want %0d/%b", cyc, timeout, e.cyc, e.to);
      else passed++;
      req = 1;
      req_mask = 4'b0011;
      tick;
      req = 0;
      total++;
      if (req_drop !== 1'b1 || busy !== 1'b0 || ack !== 1'b0)
         $display("FAIL drop_done req_drop=%b busy=%b ack=%b want 1/0/0", req_drop, busy, ack);
      else passed++;
      tick;
      total++;
      if (busy !== 1'b0 || resetB !== 4'b1111 || req_drop !== 1'b0)
         $display("FAIL drop_idle busy=%b resetB=%b req_drop=%b want 0/1111/0", busy, resetB, req_drop);
      else passed++;
      repeat (3) tick;
      total++;
      if (acks !== a0 + 1) $display("FAIL drop_ack_count got %0d want %0d", acks - a0, 1);
      else passed++;
   endtask

   task test_mask0;
      req = 1;
      req_mask = 4'b0000;
      tick;
      req = 0;
      sb.push_back('{cyc, 1'b0});
      total++;
      if (busy !== 1'b0 || resetB !== 4'b1111)
         $display("FAIL m0_state busy=%b resetB=%b want 0/1111", busy, resetB);
      else passed++;
      wait_ack(2, ok);
      e = sb.pop_front();
      total++;
      if (!ok) $display("FAIL m0_ack missing, want at cycle %0d", e.cyc);
      else if (cyc !== e.cyc || timeout !== e.to)
         $display("FAIL m0_ack cycle=%0d timeout=%b want %0d/%b", cyc, timeout, e.cyc, e.to);
      else passed++;
      tick;
      total++;
      if (ack !== 1'b0 || busy !== 1'b0 || resetB !== 4'b1111)
         $display("FAIL m0_after ack=%b busy=%b resetB=%b want 0/0/1111", ack, busy, resetB);
      else passed++;
   endtask

   task test_rst_mid;
      ch_ready = 4'b0000;
      req = 1;
      req_mask = 4'b1111;
      tick;
      req = 0;
      repeat (20) tick;
      total++;
      if (resetB !== 4'b1111 || busy !== 1'b1)
         $display("FAIL mid_wait resetB=%b busy=%b want 1111/1", resetB, busy);
      else passed++;
      a0 = acks;
      rst = 1;
      #1;
      total++;
      if (resetB !== 4'b0000 || busy !== 1'b1 || por_done !== 1'b0)
         $display("FAIL mid_async resetB=%b busy=%b por_done=%b want 0000/1/0", resetB, busy, por_done);
      else passed++;
      tick;
      rst = 0;
      ch_ready = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         tick;
         total++;
         if (resetB !== 4'b0000 || por_done !== 1'b0)
            $display("FAIL mid_por[%0d] resetB=%b por_done=%b want 0000/0", i, resetB, por_done);
         else passed++;
      end
      tick;
      total++;
      if (resetB !== 4'b1111 || por_done !== 1'b1)
         $display("FAIL mid_release resetB=%b por_done=%b want 1111/1", resetB, por_done);
      else passed++;
      repeat (5) tick;
      total++;
      if (acks !== a0 || sb.size() != 0 || busy !== 1'b0)
         $display("FAIL mid_no_ack acks=%0d pending=%0d busy=%b want %0d/0/0", acks, sb.size(), busy, a0);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_mask_0101;
      test_timeout;
      test_ready_late;
      test_back_to_back;
      test_mask0;
      test_rst_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
